crop_stream_mp: RTL

Removes a fixed border from a raster-ordered pixel stream: drops CROP_TOP/CROP_BOTTOM rows and CROP_LEFT/CROP_RIGHT columns of every INPUT_HEIGHT x INPUT_WIDTH frame and forwards only the interior. It is the inverse of the zero-pad stage and strips padding rows and columns from the output of a padded convolution or pool layer. The output is registered through a 2-entry skid buffer, so both sides sustain one pixel per clock and no combinational path runs from stream_out_ready to stream_in_ready.

---
 rtl/crop_stream_mp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/crop_stream_mp.sv
// Strips a fixed border from a raster-ordered pixel stream and forwards the interior.
// Kept pixels pass through a 2-entry skid buffer, so stream_in_ready depends only on registers.
module crop_stream_mp #(
    parameter int STREAM_WIDTH = 8,
    parameter int INPUT_HEIGHT = 225,
    parameter int INPUT_WIDTH  = 225,
    parameter int CROP_TOP     = 0,
    parameter int CROP_BOTTOM  = 1,
    parameter int CROP_LEFT    = 0,
    parameter int CROP_RIGHT   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [STREAM_WIDTH-1:0] stream_in,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    output logic [STREAM_WIDTH-1:0] stream_out,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic                    stream_out_last
);
    localparam int RW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
    localparam int CW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    localparam logic [RW-1:0] ROW_MAX  = RW'(INPUT_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(INPUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(INPUT_HEIGHT - CROP_BOTTOM - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(INPUT_WIDTH - CROP_RIGHT - 1);

    generate
        if (CROP_TOP + CROP_BOTTOM >= INPUT_HEIGHT) begin : g_bad_height
            $error("crop_stream_mp: CROP_TOP+CROP_BOTTOM must be below INPUT_HEIGHT");
        end
        if (CROP_LEFT + CROP_RIGHT >= INPUT_WIDTH) begin : g_bad_width
            $error("crop_stream_mp: CROP_LEFT+CROP_RIGHT must be below INPUT_WIDTH");
        end
    endgenerate

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic row_lo_ok, row_hi_ok, col_lo_ok, col_hi_ok;

    // Zero crops make a bound trivially true; skipping the compare keeps it free of constant tests.
    generate
        if (CROP_TOP == 0) begin : g_row_lo
            assign row_lo_ok = 1'b1;
        end else begin : g_row_lo
            assign row_lo_ok = (row >= RW'(CROP_TOP));
        end
        if (CROP_BOTTOM == 0) begin : g_row_hi
            assign row_hi_ok = 1'b1;
        end else begin : g_row_hi
            assign row_hi_ok = (row < RW'(INPUT_HEIGHT - CROP_BOTTOM));
        end
        if (CROP_LEFT == 0) begin : g_col_lo
            assign col_lo_ok = 1'b1;
        end else begin : g_col_lo
            assign col_lo_ok = (col >= CW'(CROP_LEFT));
        end
        if (CROP_RIGHT == 0) begin : g_col_hi
            assign col_hi_ok = 1'b1;
        end else begin : g_col_hi
            assign col_hi_ok = (col < CW'(INPUT_WIDTH - CROP_RIGHT));
        end
    endgenerate

    logic keep, last_in, in_fire, wr, rd;
    logic [1:0] occ;
    logic [STREAM_WIDTH-1:0] data0, data1;
    logic last0, last1;

    assign keep    = row_lo_ok & row_hi_ok & col_lo_ok & col_hi_ok;
    assign last_in = (row == ROW_LAST) & (col == COL_LAST);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    assign stream_in_ready  = (occ != 2'd2);
    assign stream_out_valid = (occ != 2'd0);
    assign stream_out       = data0;
    assign stream_out_last  = last0;

    assign in_fire = stream_in_valid & stream_in_ready;
    assign wr      = in_fire & keep;
    assign rd      = stream_out_valid & stream_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            col   <= '0;
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            if (in_fire) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // Entry 0 is always the head; entry 1 only holds data when occ is 2.
            case ({wr, rd})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= stream_in;
                        last0 <= last_in;
                    end else begin
                        data1 <= stream_in;
                        last1 <= last_in;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        data0 <= stream_in;
                        last0 <= last_in;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= stream_in;
                        last1 <= last_in;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
